// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the request, external-ALU and result channels of alu_sequencer.
//   op_*       : request channel (valid/ready, operands, opcode)
//   alu_*      : operands/control out to an external combinational ALU and its
//                result back in the same cycle
//   res_*      : result channel (valid/ready, data, zero/neg/ovf/err flags)
// master : the environment side (requester, ALU, result consumer)
// slave  : the sequencer side
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int WIDTH = 11
);
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_code;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_ctrl;
    logic [31:0]      alu_result;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_zero;
    logic             res_neg;
    logic             res_ovf;
    logic             res_err;

    modport master (
        output op_valid, op_a, op_b, op_code,
        input  op_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result,
        input  res_valid, res_data, res_zero, res_neg, res_ovf, res_err,
        output res_ready
    );

    modport slave (
        input  op_valid, op_a, op_b, op_code,
        output op_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result,
        output res_valid, res_data, res_zero, res_neg, res_ovf, res_err,
        input  res_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Sequences ADD / SUB / MUL requests on signed WIDTH-bit operands through an
// external 32-bit combinational add/subtract ALU. ADD/SUB take one ALU cycle;
// MUL is shift-and-add over WIDTH cycles, subtracting the partial product of
// the operand-B sign bit so the product is correctly signed.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : alu_sequencer_if.slave (request, ALU and result channels)
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int WIDTH = 11
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    alu_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_MUL    = 2'b10;
    localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

    state_t        r_state;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_acc;
    logic [1:0]    r_op;
    logic [4:0]    r_cnt;
    logic          r_op_ready;
    logic          r_res_valid;
    logic [31:0]   r_res_data;
    logic          r_res_zero;
    logic          r_res_neg;
    logic          r_res_ovf;
    logic          r_res_err;

    logic [31:0]   w_a_ext;
    logic [31:0]   w_b_ext;
    logic [31:0]   w_a_shift;
    logic [32-WIDTH:0] w_hi;
    logic          w_ovf;
    logic [31:0]   w_alu_a;
    logic [31:0]   w_alu_b;
    logic [2:0]    w_alu_ctrl;

    assign w_a_ext   = {{(32-WIDTH){bus.op_a[WIDTH-1]}}, bus.op_a};
    assign w_b_ext   = {{(32-WIDTH){bus.op_b[WIDTH-1]}}, bus.op_b};
    assign w_a_shift = r_a << r_cnt;

    // The result fits the operand range only if bits [31:WIDTH-1] are a pure
    // sign extension (all ones or all zeros).
    assign w_hi  = bus.alu_result[31:WIDTH-1];
    assign w_ovf = ~((&w_hi) | ~(|w_hi));

    // ALU drive is decoded from registered state so the external ALU result
    // is ready for capture at the next edge. The MSB iteration of a multiply
    // subtracts, since bit WIDTH-1 of B carries weight -2^(WIDTH-1).
    always_comb begin
        w_alu_a    = 32'd0;
        w_alu_b    = 32'd0;
        w_alu_ctrl = 3'b000;
        case (r_state)
            EXEC: begin
                w_alu_a    = r_a;
                w_alu_b    = r_b;
                w_alu_ctrl = (r_op == OP_SUB) ? 3'b001 : 3'b000;
            end
            MUL: begin
                w_alu_a    = r_acc;
                w_alu_b    = r_b[r_cnt] ? w_a_shift : 32'd0;
                w_alu_ctrl = ((r_cnt == LAST_ITER) && r_b[r_cnt]) ? 3'b001 : 3'b000;
            end
            default: ;
        endcase
    end

    // Main sequencer. op_ready is a register so that it stays low during reset
    // and rises only on the first clock edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_acc       <= 32'd0;
            r_op        <= 2'b00;
            r_cnt       <= 5'd0;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'd0;
            r_res_zero  <= 1'b0;
            r_res_neg   <= 1'b0;
            r_res_ovf   <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_op_ready <= 1'b1;
                    if (bus.op_valid && r_op_ready) begin
                        r_a        <= w_a_ext;
                        r_b        <= w_b_ext;
                        r_op       <= bus.op_code;
                        r_acc      <= 32'd0;
                        r_cnt      <= 5'd0;
                        r_op_ready <= 1'b0;
                        if (bus.op_code == OP_ADD || bus.op_code == OP_SUB) begin
                            r_state <= EXEC;
                        end else if (bus.op_code == OP_MUL) begin
                            r_state <= MUL;
                        end else begin
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                            r_res_data  <= 32'd0;
                            r_res_zero  <= 1'b0;
                            r_res_neg   <= 1'b0;
                            r_res_ovf   <= 1'b0;
                            r_res_err   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_state     <= DONE;
                    r_res_valid <= 1'b1;
                    r_res_data  <= bus.alu_result;
                    r_res_zero  <= (bus.alu_result == 32'd0);
                    r_res_neg   <= bus.alu_result[31];
                    r_res_ovf   <= w_ovf;
                    r_res_err   <= 1'b0;
                end
                MUL: begin
                    r_acc <= bus.alu_result;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST_ITER) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                        r_res_data  <= bus.alu_result;
                        r_res_zero  <= (bus.alu_result == 32'd0);
                        r_res_neg   <= bus.alu_result[31];
                        r_res_ovf   <= w_ovf;
                        r_res_err   <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_op_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.op_ready  = r_op_ready;
    assign bus.alu_a     = w_alu_a;
    assign bus.alu_b     = w_alu_b;
    assign bus.alu_ctrl  = w_alu_ctrl;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_zero  = r_res_zero;
    assign bus.res_neg   = r_res_neg;
    assign bus.res_ovf   = r_res_ovf;
    assign bus.res_err   = r_res_err;
endmodule
